// File: rtl/noc_router_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_router_pkg : shared router types, defaults and small helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package noc_router_pkg;

  localparam int DEFAULT_VC            = 4;
  localparam int DEFAULT_REQUEST_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DRAIN  = 2'd2
  } sched_state_e;

  // Index width that stays legal for a single-entry arbiter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/route_compute_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// route_compute_scheduler_if : VC-side and decoder-side signals of the scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
interface route_compute_scheduler_if #(
  parameter int VC            = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int PhitPerFlit   = 2,
  parameter int REQUEST_WIDTH = 3
) ();
  localparam int FW = PhitPerFlit * DATA_WIDTH;

  logic [VC-1:0]               vc_head_valid;
  logic [VC*FW-1:0]            vc_head_flit;
  logic [VC-1:0]               vc_route_release;
  logic [VC-1:0]               vc_route_valid;
  logic [VC*REQUEST_WIDTH-1:0] vc_route;
  logic                        decodeHeadFlit;
  logic [FW-1:0]               HeadFlit;
  logic [REQUEST_WIDTH-1:0]    RequestMessage;
  logic                        headFlitDecoded;
  logic                        busy;

  // master: the scheduler itself; slave: VC buffers plus the shared decoder
  modport master (
    input  vc_head_valid, vc_head_flit, vc_route_release, RequestMessage, headFlitDecoded,
    output vc_route_valid, vc_route, decodeHeadFlit, HeadFlit, busy
  );

  modport slave (
    output vc_head_valid, vc_head_flit, vc_route_release, RequestMessage, headFlitDecoded,
    input  vc_route_valid, vc_route, decodeHeadFlit, HeadFlit, busy
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, search starts after last grant
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
  import noc_router_pkg::*;
#(
  parameter int VC = DEFAULT_VC,
  parameter int IW = idx_width(VC)
) (
  input  logic [VC-1:0] req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [VC-1:0] grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          valid_o
);

  int          cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = last_grant_i;
    valid_o     = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= VC; k++) begin
      cand = int'(last_grant_i) + k;
      if (cand >= VC) cand = cand - VC;
      cand_idx = IW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/route_compute_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// route_compute_scheduler : shares one head-flit decoder among VCs, round-robin
// Rev 1.0
// ---------------------------------------------------------------------------
module route_compute_scheduler
  import noc_router_pkg::*;
#(
  parameter int VC            = DEFAULT_VC,
  parameter int DATA_WIDTH    = 8,
  parameter int PhitPerFlit   = 2,
  parameter int REQUEST_WIDTH = DEFAULT_REQUEST_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  route_compute_scheduler_if.master bus
);

  localparam int FW = PhitPerFlit * DATA_WIDTH;
  localparam int IW = idx_width(VC);

  sched_state_e                state_q, state_d;
  logic [FW-1:0]               head_flit_q, head_flit_d;
  logic [IW-1:0]               grant_idx_q, grant_idx_d;
  logic [IW-1:0]               last_grant_q, last_grant_d;
  logic [VC-1:0]               route_valid_q, route_valid_d;
  logic [VC*REQUEST_WIDTH-1:0] route_q, route_d;

  logic [VC-1:0] eligible;
  logic [VC-1:0] arb_grant;
  logic [IW-1:0] arb_idx;
  logic          arb_valid;

  // A routed VC stays out of arbitration until its tail releases the route.
  assign eligible = bus.vc_head_valid & ~route_valid_q;

  rr_arbiter #(
    .VC (VC),
    .IW (IW)
  ) u_rr_arbiter (
    .req_i        (eligible),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx),
    .valid_o      (arb_valid)
  );

  always_comb begin
    state_d       = state_q;
    head_flit_d   = head_flit_q;
    grant_idx_d   = grant_idx_q;
    last_grant_d  = last_grant_q;
    route_valid_d = route_valid_q & ~bus.vc_route_release;
    route_d       = route_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d      = ST_DECODE;
          grant_idx_d  = arb_idx;
          last_grant_d = arb_idx;
          head_flit_d  = '0;
          for (int i = 0; i < VC; i++) begin
            if (arb_grant[i]) head_flit_d = bus.vc_head_flit[i*FW +: FW];
          end
        end
      end
      ST_DECODE: begin
        if (bus.headFlitDecoded) begin
          state_d = ST_DRAIN;
          for (int i = 0; i < VC; i++) begin
            if (grant_idx_q == IW'(i)) begin
              route_valid_d[i]                          = 1'b1;
              route_d[i*REQUEST_WIDTH +: REQUEST_WIDTH] = bus.RequestMessage;
            end
          end
        end
      end
      // Wait for the decoder to drop its done flag so one result is never reused.
      ST_DRAIN: begin
        if (!bus.headFlitDecoded) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      head_flit_q   <= '0;
      grant_idx_q   <= '0;
      last_grant_q  <= IW'(VC - 1);
      route_valid_q <= '0;
      route_q       <= '0;
    end else begin
      state_q       <= state_d;
      head_flit_q   <= head_flit_d;
      grant_idx_q   <= grant_idx_d;
      last_grant_q  <= last_grant_d;
      route_valid_q <= route_valid_d;
      route_q       <= route_d;
    end
  end

  assign bus.decodeHeadFlit = (state_q == ST_DECODE);
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.HeadFlit       = head_flit_q;
  assign bus.vc_route_valid = route_valid_q;
  assign bus.vc_route       = route_q;

endmodule
`default_nettype wire

// File: doc/route_compute_scheduler.md
ROUTE_COMPUTE_SCHEDULER -- requirements
Module: route_compute_scheduler

Interface
REQ-001 Parameter VC, default 4, number of virtual channels sharing one HeadFlitDecoder.
REQ-002 Parameter DATA_WIDTH, default 8, phit width in bits.
REQ-003 Parameter PhitPerFlit, default 2, phits per flit; flit width FW = PhitPerFlit*DATA_WIDTH.
REQ-004 Parameter REQUEST_WIDTH, default 3, output-port request code width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 vc_head_valid  in  VC  bit i: VC i holds an unrouted head flit.
REQ-008 vc_head_flit  in  VC*FW  head flit of VC i at [i*FW +: FW].
REQ-009 vc_route_release  in  VC  bit i: one-cycle pulse, VC i tail flit sent, route freed.
REQ-010 vc_route_valid  out  VC  bit i: vc_route for VC i is valid.
REQ-011 vc_route  out  VC*REQUEST_WIDTH  route of VC i at [i*REQUEST_WIDTH +: REQUEST_WIDTH].
REQ-012 decodeHeadFlit  out  1  decode request to the shared decoder.
REQ-013 HeadFlit  out  FW  registered flit presented to the decoder.
REQ-014 RequestMessage  in  REQUEST_WIDTH  decoder result.
REQ-015 headFlitDecoded  in  1  decoder completion; RequestMessage valid while high.
REQ-016 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-017 VC i eligible when vc_head_valid[i]=1 and vc_route_valid[i]=0.
REQ-018 FSM states IDLE, DECODE, DRAIN; encoding from shared package.
REQ-019 IDLE: if any eligible, grant one VC round-robin, latch its flit into HeadFlit, store grant index, go DECODE; else stay.
REQ-020 Round-robin: search starts at (last_grant+1) mod VC; last_grant updates only on grant.
REQ-021 DECODE: decodeHeadFlit=1; HeadFlit and grant index held stable; no timeout.
REQ-022 DECODE with headFlitDecoded=1 at an edge: capture RequestMessage into vc_route[grant], set vc_route_valid[grant], go DRAIN.
REQ-023 DRAIN: decodeHeadFlit=0; go IDLE on first edge with headFlitDecoded=0.
REQ-024 Latency: eligible at edge N (FSM IDLE), combinational decoder -> decodeHeadFlit high cycle N+1, vc_route_valid high cycle N+2; next grant no earlier than N+3.
REQ-025 vc_route_release[i]=1 clears vc_route_valid[i] next edge; vc_route[i] holds last value.
REQ-026 Release on a VC with vc_route_valid=0 ignored.
REQ-027 Release and capture same edge, different VCs: both take effect.
REQ-028 vc_head_valid of granted VC dropping during DECODE does not abort; result still captured.
REQ-029 Decoded VC not re-eligible until released (no double routing of one packet).
REQ-030 headFlitDecoded high while IDLE ignored.

Reset
REQ-031 rst=1 forces immediately: FSM IDLE, decodeHeadFlit=0, HeadFlit=0, busy=0, vc_route_valid=0, vc_route=0, last_grant=VC-1 (VC0 first).
REQ-032 Reset mid-DECODE discards the transaction; no route written; decoder sees decodeHeadFlit fall asynchronously.

Structure
REQ-033 Shared package noc_router_pkg holds FSM state encoding and default VC/REQUEST_WIDTH constants.
REQ-034 Round-robin selection in sub-module rr_arbiter (VC requests, last_grant -> one-hot grant + index), combinational.
REQ-035 Decoder instantiated outside this block; single decoder per input port.

Verification
REQ-036 VC=4, only VC2 head_valid, flit 0x0012, decoder returns 3 same cycle -> decodeHeadFlit cycle 1, vc_route_valid=4'b0100, vc_route[2]=3 cycle 2.
REQ-037 All four VCs head_valid at once after reset -> grants in order 0,1,2,3, each vc_route_valid bit rising 3 cycles apart.
REQ-038 Decoder delays headFlitDecoded 5 cycles -> decodeHeadFlit and HeadFlit stable all 5 cycles, single capture, no extra grant.
REQ-039 VC1 routed, release pulse on VC1 while VC1 head_valid stays high -> vc_route_valid[1] falls next edge, VC1 re-granted and re-decoded.
REQ-040 rst asserted during DECODE for VC3 -> all outputs 0 that cycle; after release next grant is VC0 if eligible; vc_route_valid[3]=0.
REQ-041 Release on VC0 and capture for VC2 on same edge -> vc_route_valid goes from 4'b0001 to 4'b0100.
